usrt_ctrl: RTL and testbench

APB-side controller for the USRT peripheral. It decodes a 4-register APB map and holds the baud divisor and control bits that drive the shifters. It sequences transmit frames into the TX shift register through a one-entry holding register and a start/done handshake. It captures completed RX bytes with overrun detection and raises a level interrupt.

---
 rtl/usrt_pkg.sv | 28 ++
 rtl/usrt_tx_seq.sv | 64 ++++++
 rtl/usrt_ctrl.sv | 121 ++++++++++++
 tb/tb_usrt_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT controller: register map, bit positions,
// default divisor and TX sequencer state encoding.
package usrt_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_BAUD   = 2'd3;

    localparam int STAT_HOLD_FULL  = 0;
    localparam int STAT_TX_BUSY    = 1;
    localparam int STAT_RX_VALID   = 2;
    localparam int STAT_RX_OVERRUN = 3;

    localparam int CTRL_TX_EN = 0;
    localparam int CTRL_RX_EN = 1;
    localparam int CTRL_RX_IE = 2;
    localparam int CTRL_TX_IE = 3;
    localparam int CTRL_BITS  = 4;

    localparam int BAUD_DEFAULT = 87;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_BUSY = 1'b1
    } tx_state_t;

endpackage

// File: rtl/usrt_tx_seq.sv
// TX sequencer: one-entry holding register feeding the TX shifter through a
// start/done handshake.
import usrt_pkg::*;

module usrt_tx_seq #(
    parameter int P_DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [P_DW-1:0] load_data,
    input  logic            tx_en,
    input  logic            tx_done,
    output logic            busy,
    output logic            full,
    output logic            tx_start,
    output logic [P_DW-1:0] tx_data
);

    tx_state_t       state_reg;
    logic [P_DW-1:0] hold_reg;
    logic            full_reg;
    logic            tx_start_reg;
    logic [P_DW-1:0] tx_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= T_IDLE;
            hold_reg     <= '0;
            full_reg     <= 1'b0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            case (state_reg)
                T_IDLE: begin
                    if (full_reg && tx_en) begin
                        state_reg    <= T_BUSY;
                        tx_start_reg <= 1'b1;
                        tx_data_reg  <= hold_reg;
                        full_reg     <= 1'b0;
                    end
                end
                T_BUSY: begin
                    tx_start_reg <= 1'b0;
                    if (tx_done) begin
                        state_reg <= T_IDLE;
                    end
                end
                default: state_reg <= T_IDLE;
            endcase
            // Loads are only accepted while empty, so they never race the drain.
            if (load) begin
                hold_reg <= load_data;
                full_reg <= 1'b1;
            end
        end
    end

    assign busy     = (state_reg != T_IDLE);
    assign full     = full_reg;
    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;

endmodule

// File: rtl/usrt_ctrl.sv
// APB-side USRT controller: register file, APB decode, RX byte capture with
// overrun detection and the level interrupt.
import usrt_pkg::*;

module usrt_ctrl #(
    parameter int P_BAUD_RST = BAUD_DEFAULT,
    parameter int P_DW       = 8
) (
    input  logic            i_Pclk,
    input  logic            i_Preset,
    input  logic [1:0]      i_Paddr,
    input  logic            i_Psel,
    input  logic            i_Penable,
    input  logic            i_Pwrite,
    input  logic [P_DW-1:0] i_Pwdata,
    output logic            o_Pready,
    output logic [P_DW-1:0] o_Prdata,
    output logic [P_DW-1:0] o_Baud,
    output logic            o_Tx_Start,
    output logic [P_DW-1:0] o_Tx_Data,
    input  logic            i_Tx_Done,
    output logic            o_Rx_En,
    input  logic            i_Rx_Done,
    input  logic [P_DW-1:0] i_Rx_Data,
    output logic            o_Irq
);

    localparam logic [P_DW-1:0] BAUD_RST_VAL = P_BAUD_RST[P_DW-1:0];

    logic [CTRL_BITS-1:0] ctrl_reg;
    logic [P_DW-1:0]      baud_reg;
    logic [P_DW-1:0]      rx_data_reg;
    logic                 rx_valid_reg;
    logic                 rx_ovr_reg;
    logic                 irq_reg;

    logic tx_busy, tx_full;
    logic access, xfer, wr_data, rd_pop, wr_status, wr_ctrl, wr_baud;
    logic [P_DW-1:0] status_word;

    assign access    = i_Psel && i_Penable;
    // Only a DATA write into an occupied holding register has to wait.
    assign o_Pready  = !(access && i_Pwrite && (i_Paddr == ADDR_DATA) && tx_full);
    assign xfer      = access && o_Pready;
    assign wr_data   = xfer && i_Pwrite && (i_Paddr == ADDR_DATA);
    assign wr_status = xfer && i_Pwrite && (i_Paddr == ADDR_STATUS);
    assign wr_ctrl   = xfer && i_Pwrite && (i_Paddr == ADDR_CTRL);
    assign wr_baud   = xfer && i_Pwrite && (i_Paddr == ADDR_BAUD);
    assign rd_pop    = xfer && !i_Pwrite && (i_Paddr == ADDR_DATA) && rx_valid_reg;

    usrt_tx_seq #(.P_DW(P_DW)) u_tx_seq (
        .clk       (i_Pclk),
        .rst       (i_Preset),
        .load      (wr_data),
        .load_data (i_Pwdata),
        .tx_en     (ctrl_reg[CTRL_TX_EN]),
        .tx_done   (i_Tx_Done),
        .busy      (tx_busy),
        .full      (tx_full),
        .tx_start  (o_Tx_Start),
        .tx_data   (o_Tx_Data)
    );

    always_ff @(posedge i_Pclk or posedge i_Preset) begin
        if (i_Preset) begin
            ctrl_reg     <= '0;
            baud_reg     <= BAUD_RST_VAL;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            rx_ovr_reg   <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_reg <= i_Pwdata[CTRL_BITS-1:0];
            end
            if (wr_baud && (i_Pwdata != '0)) begin
                baud_reg <= i_Pwdata;
            end
            if (wr_status && i_Pwdata[STAT_RX_OVERRUN]) begin
                rx_ovr_reg <= 1'b0;
            end
            // A pop on the same edge frees the slot, so the new byte is not an overrun.
            if (i_Rx_Done && ctrl_reg[CTRL_RX_EN]) begin
                if (!rx_valid_reg || rd_pop) begin
                    rx_data_reg  <= i_Rx_Data;
                    rx_valid_reg <= 1'b1;
                end else begin
                    rx_ovr_reg <= 1'b1;
                end
            end else if (rd_pop) begin
                rx_valid_reg <= 1'b0;
            end
            irq_reg <= (ctrl_reg[CTRL_RX_IE] && (rx_valid_reg || rx_ovr_reg)) ||
                       (ctrl_reg[CTRL_TX_IE] && !tx_full && !tx_busy);
        end
    end

    always_comb begin
        status_word                  = '0;
        status_word[STAT_HOLD_FULL]  = tx_full;
        status_word[STAT_TX_BUSY]    = tx_busy;
        status_word[STAT_RX_VALID]   = rx_valid_reg;
        status_word[STAT_RX_OVERRUN] = rx_ovr_reg;
    end

    always_comb begin
        o_Prdata = '0;
        case (i_Paddr)
            ADDR_DATA:   o_Prdata = rx_valid_reg ? rx_data_reg : '0;
            ADDR_STATUS: o_Prdata = status_word;
            ADDR_CTRL:   o_Prdata = {{(P_DW-CTRL_BITS){1'b0}}, ctrl_reg};
            ADDR_BAUD:   o_Prdata = baud_reg;
            default:     o_Prdata = '0;
        endcase
    end

    assign o_Baud  = baud_reg;
    assign o_Rx_En = ctrl_reg[CTRL_RX_EN];
    assign o_Irq   = irq_reg;

endmodule

// File: tb/tb_usrt_ctrl.sv
// Bench for usrt_ctrl: directed scenarios followed by randomized APB/RX traffic
// checked against a transaction-level model, with a responsive TX shifter model.
module tb_usrt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] paddr;
    logic       psel, penable, pwrite;
    logic [7:0] pwdata;
    logic       pready;
    logic [7:0] prdata, baud, tx_data, rx_data;
    logic       tx_start, tx_done, rx_en, rx_done, irq;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    usrt_ctrl #(.P_BAUD_RST(87), .P_DW(8)) dut (
        .i_Pclk     (clk),
        .i_Preset   (rst),
        .i_Paddr    (paddr),
        .i_Psel     (psel),
        .i_Penable  (penable),
        .i_Pwrite   (pwrite),
        .i_Pwdata   (pwdata),
        .o_Pready   (pready),
        .o_Prdata   (prdata),
        .o_Baud     (baud),
        .o_Tx_Start (tx_start),
        .o_Tx_Data  (tx_data),
        .i_Tx_Done  (tx_done),
        .o_Rx_En    (rx_en),
        .i_Rx_Done  (rx_done),
        .i_Rx_Data  (rx_data),
        .o_Irq      (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] tx_q[$];
    bit         m_valid, m_ovr;
    logic [7:0] m_byte;
    logic [3:0] m_ctrl;
    logic [7:0] m_baud;
    int         done_lat  = 0;
    int         start_cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_ovr = 0; m_byte = 8'h00; m_ctrl = 4'h0; m_baud = 8'd87;
        tx_q.delete();
    endtask

    // TX shifter model: consumes each start pulse and answers with a done pulse.
    initial begin
        logic [7:0] exp_b;
        int lat;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                start_cyc = cyc;
                if (tx_q.size() == 0) begin
                    check("tx_unexpected_start", 1, 0);
                end else begin
                    exp_b = tx_q.pop_front();
                    check("tx_data", tx_data, exp_b);
                end
                $display("[TB] tx start 0x%02h at cycle %0d", tx_data, cyc);
                lat = (done_lat > 0) ? done_lat : int'($urandom_range(2, 6));
                @(negedge clk);
                check("tx_start_width", tx_start, 0);
                repeat (lat - 1) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One APB transfer, optionally with an RX byte arriving on its completion edge.
    task automatic apb(input logic wr, input logic [1:0] a, input logic [7:0] d,
                       input logic with_rx, input logic [7:0] rxb,
                       output logic [7:0] rd, output int k, output int stalls);
        int budget;
        budget = 200;
        stalls = 0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        if (with_rx) begin
            rx_done = 1'b1;
            rx_data = rxb;
        end
        forever begin
            @(negedge clk);
            if (pready) break;
            stalls++;
            budget--;
            if (budget == 0) begin
                check("apb_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        rd = prdata;
        @(posedge clk); #1;
        k = cyc;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_done = 1'b0;
        $display("[TB] apb %s addr=%0d wdata=0x%02h rdata=0x%02h stalls=%0d edge=%0d",
                 wr ? "WR" : "RD", a, d, rd, stalls, k);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d, output int k, output int stalls);
        logic [7:0] unused_rd;
        case (a)
            2'd0: tx_q.push_back(d);
            2'd1: if (d[3]) m_ovr = 0;
            2'd2: m_ctrl = d[3:0];
            default: if (d != 8'h00) m_baud = d;
        endcase
        apb(1'b1, a, d, 1'b0, 8'h00, unused_rd, k, stalls);
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [7:0] v);
        int k, st;
        apb(1'b0, a, 8'h00, 1'b0, 8'h00, v, k, st);
    endtask

    task automatic data_read_check(input string tag);
        logic [7:0] v, exp;
        exp = m_valid ? m_byte : 8'h00;
        m_valid = 0;
        reg_read(2'd0, v);
        check(tag, v, exp);
    endtask

    task automatic status_rx_check(input string tag);
        logic [7:0] v;
        reg_read(2'd1, v);
        check(tag, v & 8'h0C, {4'b0, m_ovr, m_valid, 2'b00});
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_done = 1'b0;
        if (m_ctrl[1]) begin
            if (!m_valid) begin
                m_byte  = b;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end
        $display("[TB] rx byte 0x%02h valid=%0d ovr=%0d", b, m_valid, m_ovr);
    endtask

    initial begin
        int k, k0, k1, k2, st, budget;
        logic [7:0] v;

        rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        rx_done = 0; rx_data = 0;
        model_reset();
        idle(3);
        rst = 1'b0;
        idle(1);

        // Reset state
        check("rst_baud", baud, 87);
        check("rst_pready", pready, 1);
        check("rst_tx_start", tx_start, 0);
        check("rst_rx_en", rx_en, 0);
        check("rst_irq", irq, 0);
        reg_read(2'd1, v); check("rst_status", v, 8'h00);
        reg_read(2'd2, v); check("rst_ctrl", v, 8'h00);

        // BAUD
        reg_write(2'd3, 8'h00, k, st);
        reg_read(2'd3, v); check("baud_zero_ignored", v, 87);
        reg_write(2'd3, 8'h1A, k, st);
        check("baud_out", baud, 8'h1A);
        reg_read(2'd3, v); check("baud_read", v, m_baud);

        // TX handshake
        reg_write(2'd2, 8'h01, k, st);
        done_lat = 12;
        reg_write(2'd0, 8'hA5, k, st);
        idle(2);
        check("tx_start_latency", start_cyc, k + 1);
        reg_read(2'd1, v); check("tx_status_busy", v, 8'h02);
        idle(15);
        reg_read(2'd1, v); check("tx_status_idle", v, 8'h00);
        reg_write(2'd2, 8'h09, k, st);
        idle(1);
        check("tx_ie_irq", irq, 1);
        reg_write(2'd2, 8'h01, k, st);

        // TX stall on a full holding register
        done_lat = 15;
        reg_write(2'd0, 8'hA0, k0, st);
        reg_write(2'd0, 8'h11, k1, st);
        check("hold_load_no_stall", st, 0);
        reg_write(2'd0, 8'h22, k2, st);
        check("stall_seen", st > 0, 1);
        check("stall_release_edge", k2, start_cyc + 1);
        idle(40);
        check("stall_drained", tx_q.size(), 0);
        reg_read(2'd1, v); check("stall_status_idle", v, 8'h00);

        // RX overrun
        reg_write(2'd2, 8'h06, k, st);
        rx_pulse(8'h3C);
        rx_pulse(8'h7E);
        idle(1);
        check("ovr_irq", irq, 1);
        reg_read(2'd1, v); check("ovr_status", v, 8'h0C);
        check("ovr_model_byte", m_byte, 8'h3C);
        data_read_check("ovr_data");
        reg_read(2'd1, v); check("ovr_status_after_pop", v, 8'h08);
        idle(1);
        check("ovr_irq_held", irq, 1);
        reg_write(2'd1, 8'h08, k, st);
        idle(1);
        check("ovr_irq_cleared", irq, 0);

        // Pop and receive on the same edge
        rx_pulse(8'h99);
        apb(1'b0, 2'd0, 8'h00, 1'b1, 8'h55, v, k, st);
        check("sim_old_byte", v, 8'h99);
        reg_read(2'd1, v); check("sim_status", v, 8'h04);
        reg_read(2'd0, v); check("sim_new_byte", v, 8'h55);
        reg_read(2'd1, v); check("sim_no_overrun", v, 8'h00);
        m_valid = 0;

        // Reset mid-frame
        reg_write(2'd2, 8'h01, k, st);
        done_lat = 30;
        reg_write(2'd0, 8'h5A, k, st);
        idle(3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_baud", baud, 87);
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_pready", pready, 1);
        check("mid_rst_rx_en", rx_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        reg_read(2'd1, v); check("mid_rst_status", v, 8'h00);
        idle(35);
        done_lat = 0;

        // Randomized traffic
        reg_write(2'd2, 8'h07, k, st);
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0: reg_write(2'd0, 8'($urandom), k, st);
                1: rx_pulse(8'($urandom));
                2: data_read_check("rnd_data");
                3: status_rx_check("rnd_status");
                default: reg_write(2'd1, 8'h08, k, st);
            endcase
            idle(1);
            check("rnd_irq", irq, m_ctrl[2] & (m_valid | m_ovr));
        end
        budget = 300;
        while (tx_q.size() > 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        idle(10);
        check("rnd_tx_drained", tx_q.size(), 0);
        reg_read(2'd1, v); check("rnd_final_status", v & 8'h0C, {4'b0, m_ovr, m_valid, 2'b00});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
